// File: rtl/interface_arb_pkg.sv
// rtl/interface_arb_pkg.sv - shared types and width helpers for the round-robin resource arbiter
package interface_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter must be able to hold the value TimeoutCycles-1.
    function automatic int cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles + 1) : 1;
    endfunction

    localparam int DefTimeoutCntW = cnt_w(16);

endpackage

// File: rtl/interface_rr_pick.sv
// rtl/interface_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module interface_rr_pick
    import interface_arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int IdxW   = idx_w(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   idx,
    output logic              any
);

    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            j = int'(ptr) + i;
            if (j >= NumReq) begin
                j = j - NumReq;
            end
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/interface_rr_arbiter.sv
// rtl/interface_rr_arbiter.sv - round-robin arbiter serialising a/b->c transactions onto one resource
// Optional WAIT watchdog enabled by defining INTERFACE_RR_ARBITER_TIMEOUT_EN.
module interface_rr_arbiter
    import interface_arb_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int Width         = 1,
    parameter int TimeoutCycles = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NumReq-1:0]       i_req,
    input  logic [NumReq*Width-1:0] i_a,
    input  logic [NumReq*Width-1:0] i_b,
    output logic [NumReq-1:0]       o_gnt,
    output logic [NumReq-1:0]       o_done,
    output logic [Width-1:0]        o_c,
    output logic                    o_err,
    output logic [Width-1:0]        o_res_a,
    output logic [Width-1:0]        o_res_b,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    input  logic [Width-1:0]        i_res_c,
    input  logic                    i_res_c_valid
);

    localparam int IdxW = idx_w(NumReq);

    state_e            state, state_nxt;
    logic [IdxW-1:0]   ptr, ptr_nxt;
    logic [IdxW-1:0]   idx, idx_nxt;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;
    logic [NumReq-1:0] gnt_nxt, done_nxt;
    logic [Width-1:0]  c_nxt, a_nxt, b_nxt;
    logic              err_nxt, valid_nxt;
    logic              finish, timeout;

`ifdef INTERFACE_RR_ARBITER_TIMEOUT_EN
    localparam int CntW = cnt_w(TimeoutCycles);
    logic [CntW-1:0] cnt, cnt_nxt;
`endif

    interface_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req (i_req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            o_gnt       <= '0;
            o_done      <= '0;
            o_c         <= '0;
            o_err       <= 1'b0;
            o_res_a     <= '0;
            o_res_b     <= '0;
            o_res_valid <= 1'b0;
`ifdef INTERFACE_RR_ARBITER_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            idx         <= idx_nxt;
            o_gnt       <= gnt_nxt;
            o_done      <= done_nxt;
            o_c         <= c_nxt;
            o_err       <= err_nxt;
            o_res_a     <= a_nxt;
            o_res_b     <= b_nxt;
            o_res_valid <= valid_nxt;
`ifdef INTERFACE_RR_ARBITER_TIMEOUT_EN
            cnt         <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        gnt_nxt   = o_gnt;
        done_nxt  = '0;
        c_nxt     = o_c;
        err_nxt   = o_err;
        a_nxt     = o_res_a;
        b_nxt     = o_res_b;
        valid_nxt = o_res_valid;
        finish    = 1'b0;
        timeout   = 1'b0;
`ifdef INTERFACE_RR_ARBITER_TIMEOUT_EN
        cnt_nxt   = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    idx_nxt           = pick_idx;
                    a_nxt             = i_a[int'(pick_idx)*Width +: Width];
                    b_nxt             = i_b[int'(pick_idx)*Width +: Width];
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    valid_nxt         = 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                if (i_res_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = WAIT;
`ifdef INTERFACE_RR_ARBITER_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            WAIT: begin
                finish = i_res_c_valid;
`ifdef INTERFACE_RR_ARBITER_TIMEOUT_EN
                // A result arriving on the expiry cycle takes precedence over the timeout.
                if (!i_res_c_valid) begin
                    if (cnt == CntW'(TimeoutCycles - 1)) begin
                        timeout = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CntW'(1);
                    end
                end
`endif
                if (finish || timeout) begin
                    state_nxt     = IDLE;
                    gnt_nxt       = '0;
                    done_nxt[idx] = 1'b1;
                    err_nxt       = timeout;
                    c_nxt         = timeout ? '0 : i_res_c;
                    ptr_nxt       = (idx == IdxW'(NumReq - 1)) ? '0 : idx + IdxW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_interface_rr_arbiter.sv
// tb/tb_interface_rr_arbiter.sv - randomized self-checking bench for interface_rr_arbiter
module tb_interface_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 16;
    localparam int AW = N * W;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [N-1:0]  i_req;
    logic [AW-1:0] i_a, i_b;
    logic [N-1:0]  o_gnt, o_done;
    logic [W-1:0]  o_c;
    logic          o_err;
    logic [W-1:0]  o_res_a, o_res_b;
    logic          o_res_valid;
    logic          i_res_ready;
    logic [W-1:0]  i_res_c;
    logic          i_res_c_valid;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 i_clk = ~i_clk;

    interface_rr_arbiter #(.NumReq(N), .Width(W), .TimeoutCycles(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_a(i_a), .i_b(i_b),
        .o_gnt(o_gnt), .o_done(o_done), .o_c(o_c), .o_err(o_err),
        .o_res_a(o_res_a), .o_res_b(o_res_b), .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready), .i_res_c(i_res_c), .i_res_c_valid(i_res_c_valid)
    );

    // Reference rule: first requester found scanning ptr, ptr+1, ... modulo N.
    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic hold_reset(input int n);
        i_rst = 1'b1; i_req = '0; i_res_ready = 1'b0; i_res_c_valid = 1'b0; i_res_c = '0;
        i_a = AW'($urandom); i_b = AW'($urandom);
        repeat (n) step();
        i_rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic issue_phase(input logic [N-1:0] req, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input int ready_dly, input bit hold_req,
                               output logic [N-1:0] gnt, output logic [W-1:0] ra, output logic [W-1:0] rb,
                               output int lat, output bit stable, output bit dropped);
        i_req = req; i_a = a; i_b = b;
        lat = 0; stable = 1'b1;
        do begin
            step();
            lat++;
        end while (!o_res_valid && lat < 20);
        gnt = o_gnt; ra = o_res_a; rb = o_res_b;
        if (!hold_req) begin
            i_req = '0; i_a = AW'($urandom); i_b = AW'($urandom);
        end
        for (int k = 0; k < ready_dly; k++) begin
            i_res_c_valid = 1'($urandom_range(0, 1));
            i_res_c = W'($urandom);
            step();
            if (o_res_valid !== 1'b1 || o_gnt !== gnt || o_res_a !== ra || o_res_b !== rb || o_done !== '0)
                stable = 1'b0;
        end
        i_res_c_valid = 1'b0;
        i_res_ready = 1'b1;
        step();
        dropped = (o_res_valid === 1'b0 && o_done === '0 && o_gnt === gnt);
        i_res_ready = 1'b0;
    endtask

    task automatic wait_phase(input int cv_dly, input logic [W-1:0] cval, input logic [N-1:0] gnt,
                              output logic [N-1:0] done, output logic [W-1:0] c, output logic err,
                              output logic [N-1:0] gnt_after, output bit held);
        held = 1'b1;
        for (int k = 0; k < cv_dly; k++) begin
            step();
            if (o_done !== '0 || o_gnt !== gnt || o_res_valid !== 1'b0) held = 1'b0;
        end
        i_res_c_valid = 1'b1; i_res_c = cval;
        step();
        i_res_c_valid = 1'b0; i_res_c = W'($urandom);
        done = o_done; c = o_c; err = o_err; gnt_after = o_gnt;
    endtask

    task automatic test_reset();
        logic [N-1:0] g, d, ga; logic [W-1:0] ra, rb, c; logic e; int lat; bit st, dr, hd;
        hold_reset(3);
        checks++; if ({o_gnt, o_done, o_c, o_err, o_res_a, o_res_b, o_res_valid} !== '0) begin
            errors++; $display("FAIL reset_outputs: got gnt=%b done=%b c=%h err=%b a=%h b=%h v=%b want all 0",
                               o_gnt, o_done, o_c, o_err, o_res_a, o_res_b, o_res_valid); end
        issue_phase(4'b0010, AW'($urandom), AW'($urandom), 0, 1'b0, g, ra, rb, lat, st, dr);
        wait_phase(1, W'($urandom), g, d, c, e, ga, hd);
        issue_phase(4'b1000, AW'($urandom), AW'($urandom), 0, 1'b0, g, ra, rb, lat, st, dr);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL reset_pre_gnt: got %b want 1000", g); end
        step(); step();
        i_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if ({o_gnt, o_done, o_c, o_err, o_res_a, o_res_b, o_res_valid} !== '0) begin
                errors++; $display("FAIL reset_midwait[%0d]: got gnt=%b done=%b v=%b want all 0",
                                   k, o_gnt, o_done, o_res_valid); end
        end
        i_rst = 1'b0; m_ptr = 0;
        issue_phase(4'b1111, AW'($urandom), AW'($urandom), 0, 1'b0, g, ra, rb, lat, st, dr);
        checks++; if (g !== onehot(model_pick(4'b1111, m_ptr)) || lat != 1) begin
            errors++; $display("FAIL reset_regrant: got gnt=%b lat=%0d want %b lat=1", g, lat, onehot(0)); end
        wait_phase(0, W'($urandom), g, d, c, e, ga, hd);
        m_ptr = 1;
        i_req = '0;
    endtask

    task automatic test_single();
        logic [N-1:0] g, d, ga; logic [W-1:0] ra, rb, c; logic e; int lat; bit st, dr, hd;
        logic [AW-1:0] a, b;
        a = AW'($urandom); b = AW'($urandom);
        a[1*W +: W] = W'(1); b[1*W +: W] = W'(0);
        issue_phase(4'b0010, a, b, 0, 1'b0, g, ra, rb, lat, st, dr);
        checks++; if (g !== 4'b0010 || lat != 1) begin
            errors++; $display("FAIL single_gnt: got %b lat=%0d want 0010 lat=1", g, lat); end
        checks++; if (ra !== W'(1) || rb !== W'(0)) begin
            errors++; $display("FAIL single_ab: got a=%h b=%h want a=1 b=0", ra, rb); end
        checks++; if (!dr) begin errors++; $display("FAIL single_handshake: got valid=%b want 0", o_res_valid); end
        wait_phase(1, W'(1), g, d, c, e, ga, hd);
        checks++; if (!hd) begin errors++; $display("FAIL single_wait_hold: got gnt=%b want 0010", o_gnt); end
        checks++; if (d !== 4'b0010 || c !== W'(1) || e !== 1'b0 || ga !== '0) begin
            errors++; $display("FAIL single_done: got done=%b c=%h err=%b gnt=%b want 0010 1 0 0000", d, c, e, ga); end
        m_ptr = 2;
        i_req = '0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] g, d, ga; logic [W-1:0] ra, rb, c; logic e; int lat; bit st, dr, hd;
        hold_reset(2);
        for (int i = 0; i < 8; i++) begin
            issue_phase(4'b1111, AW'($urandom), AW'($urandom), 0, 1'b1, g, ra, rb, lat, st, dr);
            checks++; if (g !== onehot(model_pick(4'b1111, m_ptr)) || g !== onehot(i % N) || lat != 1) begin
                errors++; $display("FAIL fair_gnt[%0d]: got %b lat=%0d want %b", i, g, lat, onehot(i % N)); end
            wait_phase(0, W'($urandom), g, d, c, e, ga, hd);
            checks++; if (d !== g) begin errors++; $display("FAIL fair_done[%0d]: got %b want %b", i, d, g); end
            m_ptr = (i % N + 1) % N;
        end
        i_req = '0;
    endtask

    task automatic test_wrap();
        logic [N-1:0] g, d, ga; logic [W-1:0] ra, rb, c; logic e; int lat; bit st, dr, hd;
        logic [N-1:0] reqs [4];
        int want [4];
        reqs = '{4'b0100, 4'b1001, 4'b1001, 4'b1111};
        want = '{2, 3, 0, 1};
        for (int i = 0; i < 4; i++) begin
            issue_phase(reqs[i], AW'($urandom), AW'($urandom), 0, 1'b1, g, ra, rb, lat, st, dr);
            checks++; if (g !== onehot(want[i]) || g !== onehot(model_pick(reqs[i], m_ptr))) begin
                errors++; $display("FAIL wrap_gnt[%0d]: got %b want %b", i, g, onehot(want[i])); end
            wait_phase($urandom_range(0, 2), W'($urandom), g, d, c, e, ga, hd);
            m_ptr = (want[i] + 1) % N;
        end
        i_req = '0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g, d, ga, req; logic [W-1:0] ra, rb, c, cv; logic e; int lat, ex; bit st, dr, hd;
        logic [AW-1:0] a, b;
        for (int i = 0; i < 2; i++) begin
            req = N'($urandom_range(1, 15)); a = AW'($urandom); b = AW'($urandom); cv = W'($urandom);
            ex = model_pick(req, m_ptr);
            issue_phase(req, a, b, 5, 1'b0, g, ra, rb, lat, st, dr);
            checks++; if (!st || ra !== a[ex*W +: W] || rb !== b[ex*W +: W]) begin
                errors++; $display("FAIL bp_stable[%0d]: got stable=%b a=%h b=%h want 1 %h %h",
                                   i, st, ra, rb, a[ex*W +: W], b[ex*W +: W]); end
            wait_phase(2, cv, g, d, c, e, ga, hd);
            checks++; if (d !== onehot(ex) || c !== cv || !hd || !dr) begin
                errors++; $display("FAIL bp_done[%0d]: got done=%b c=%h held=%b drop=%b want %b %h 1 1",
                                   i, d, c, hd, dr, onehot(ex), cv); end
            m_ptr = (ex + 1) % N;
        end
        i_req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] g, d, ga, req; logic [W-1:0] ra, rb, c, cv; logic e; int lat, ex; bit st, dr, hd;
        logic [AW-1:0] a, b;
        for (int i = 0; i < 20; i++) begin
            req = N'($urandom_range(1, 15)); a = AW'($urandom); b = AW'($urandom); cv = W'($urandom);
            ex = model_pick(req, m_ptr);
            issue_phase(req, a, b, $urandom_range(0, 4), 1'($urandom_range(0, 1)), g, ra, rb, lat, st, dr);
            checks++; if (g !== onehot(ex) || lat != 1) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b lat=%0d want %b (req=%b ptr=%0d)", i, g, lat, onehot(ex), req, m_ptr); end
            checks++; if (ra !== a[ex*W +: W] || rb !== b[ex*W +: W] || !st || !dr) begin
                errors++; $display("FAIL rand_issue[%0d]: got a=%h b=%h st=%b dr=%b want %h %h 1 1",
                                   i, ra, rb, st, dr, a[ex*W +: W], b[ex*W +: W]); end
            wait_phase($urandom_range(0, 6), cv, g, d, c, e, ga, hd);
            checks++; if (d !== onehot(ex) || c !== cv || e !== 1'b0 || ga !== '0 || !hd) begin
                errors++; $display("FAIL rand_done[%0d]: got done=%b c=%h err=%b gnt=%b held=%b want %b %h 0 0000 1",
                                   i, d, c, e, ga, hd, onehot(ex), cv); end
            m_ptr = (ex + 1) % N;
        end
        i_req = '0;
    endtask

    task automatic test_timeout();
        logic [N-1:0] g, req; logic [W-1:0] ra, rb, cv; int lat, ex, n; bit st, dr;
        for (int i = 0; i < 2; i++) begin
            req = N'($urandom_range(1, 15)); cv = W'($urandom_range(1, 15));
            ex = model_pick(req, m_ptr);
            issue_phase(req, AW'($urandom), AW'($urandom), 0, 1'b0, g, ra, rb, lat, st, dr);
`ifdef INTERFACE_RR_ARBITER_TIMEOUT_EN
            n = 0;
            do begin
                if (i == 1 && n == TO - 1) begin
                    i_res_c_valid = 1'b1; i_res_c = cv;
                end
                step();
                n++;
                i_res_c_valid = 1'b0;
            end while (o_done === '0 && n < 3 * TO);
            checks++; if (n != TO || o_done !== onehot(ex)) begin
                errors++; $display("FAIL timeout_latency[%0d]: got %0d cycles done=%b want %0d %b", i, n, o_done, TO, onehot(ex)); end
            checks++; if (o_err !== (i == 0) || o_c !== ((i == 0) ? W'(0) : cv)) begin
                errors++; $display("FAIL timeout_result[%0d]: got err=%b c=%h want %b %h",
                                   i, o_err, o_c, (i == 0), (i == 0) ? W'(0) : cv); end
`else
            n = 0;
            for (int k = 0; k < 3 * TO; k++) begin
                step();
                if (o_done !== '0 || o_err !== 1'b0 || o_gnt !== g) n++;
            end
            checks++; if (n != 0) begin
                errors++; $display("FAIL notimeout_hold[%0d]: got %0d bad cycles want 0", i, n); end
            i_res_c_valid = 1'b1; i_res_c = cv;
            step();
            i_res_c_valid = 1'b0;
            checks++; if (o_done !== onehot(ex) || o_err !== 1'b0 || o_c !== cv) begin
                errors++; $display("FAIL notimeout_done[%0d]: got done=%b err=%b c=%h want %b 0 %h",
                                   i, o_done, o_err, o_c, onehot(ex), cv); end
`endif
            m_ptr = (ex + 1) % N;
        end
        i_req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
